// File: rtl/io_port_arbiter_if.sv
// CPU IO bus and device-port bundle for io_port_arbiter.
// master: arbiter view; slave: CPU plus device environment view.
interface io_port_arbiter_if #(
  parameter int unsigned DATABITWIDTH = 16,
  parameter int unsigned PORTCOUNT    = 4,
  parameter int unsigned REGADDRWIDTH = 4,
  parameter int unsigned MINORWIDTH   = 4
);
  logic                              IOOutREQ;
  logic                              IOOutACK;
  logic [MINORWIDTH-1:0]             IOMinorOpcode;
  logic [DATABITWIDTH-1:0]           IOOutAddress;
  logic [DATABITWIDTH-1:0]           IOOutData;
  logic [REGADDRWIDTH-1:0]           IOOutDestReg;
  logic [PORTCOUNT-1:0]              DevREQ;
  logic [PORTCOUNT-1:0]              DevACK;
  logic [MINORWIDTH-1:0]             DevMinorOpcode;
  logic [DATABITWIDTH-1:0]           DevAddress;
  logic [DATABITWIDTH-1:0]           DevData;
  logic [REGADDRWIDTH-1:0]           DevDestReg;
  logic [PORTCOUNT-1:0]              DevRespREQ;
  logic [PORTCOUNT-1:0]              DevRespACK;
  logic [PORTCOUNT*REGADDRWIDTH-1:0] DevRespDestReg;
  logic [PORTCOUNT*DATABITWIDTH-1:0] DevRespData;
  logic                              IOInREQ;
  logic                              IOInACK;
  logic [REGADDRWIDTH-1:0]           IOInDestReg;
  logic [DATABITWIDTH-1:0]           IOInData;
  logic                              TimeoutFlag;

  modport master (
    input  IOOutREQ, IOMinorOpcode, IOOutAddress, IOOutData, IOOutDestReg,
    input  DevACK, DevRespREQ, DevRespDestReg, DevRespData, IOInACK,
    output IOOutACK, DevREQ, DevMinorOpcode, DevAddress, DevData, DevDestReg,
    output DevRespACK, IOInREQ, IOInDestReg, IOInData, TimeoutFlag
  );

  modport slave (
    output IOOutREQ, IOMinorOpcode, IOOutAddress, IOOutData, IOOutDestReg,
    output DevACK, DevRespREQ, DevRespDestReg, DevRespData, IOInACK,
    input  IOOutACK, DevREQ, DevMinorOpcode, DevAddress, DevData, DevDestReg,
    input  DevRespACK, IOInREQ, IOInDestReg, IOInData, TimeoutFlag
  );
endinterface

// File: rtl/io_port_arbiter.sv
// One-deep CPU IO request buffer with address-decoded device dispatch, plus a
// round-robin response arbiter back to the CPU. IOARB_TIMEOUT_EN adds a request watchdog.
module io_port_arbiter #(
  parameter int unsigned DATABITWIDTH  = 16,
  parameter int unsigned PORTCOUNT     = 4,
  parameter int unsigned REGADDRWIDTH  = 4,
  parameter int unsigned MINORWIDTH    = 4
`ifdef IOARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUTCYCLES = 1024
`endif
) (
  input logic               clk,
  input logic               clk_en,
  input logic               sync_rst,
  io_port_arbiter_if.master bus
);
  localparam int unsigned PORTADDRBITS = (PORTCOUNT > 1) ? $clog2(PORTCOUNT) : 1;
  localparam int unsigned SELW         = PORTADDRBITS + 1;

  // ---------------- request path ----------------
  logic                    req_valid;
  logic [PORTADDRBITS-1:0] sel;
  logic [MINORWIDTH-1:0]   dev_minor;
  logic [DATABITWIDTH-1:0] dev_addr;
  logic [DATABITWIDTH-1:0] dev_data;
  logic [REGADDRWIDTH-1:0] dev_dest;
  logic                    req_accept_c;
  logic                    req_done_c;
  logic                    sel_ok_c;
  logic                    timeout_hit_c;

  assign bus.IOOutACK  = clk_en & ~sync_rst & ~req_valid;
  assign req_accept_c  = bus.IOOutREQ & bus.IOOutACK;
  // Out-of-range port selects are accepted and then silently dropped
  assign sel_ok_c      = SELW'(sel) < SELW'(PORTCOUNT);
  assign req_done_c    = clk_en & req_valid & (~sel_ok_c | bus.DevACK[sel]);

  always_comb begin : dev_req_decode
    bus.DevREQ = '0;
    if (req_valid && sel_ok_c) bus.DevREQ[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin : req_buf
    if (sync_rst) begin
      req_valid <= 1'b0;
      sel       <= '0;
      dev_minor <= '0;
      dev_addr  <= '0;
      dev_data  <= '0;
      dev_dest  <= '0;
    end else if (clk_en) begin
      if (req_accept_c) begin
        req_valid <= 1'b1;
        sel       <= bus.IOOutAddress[DATABITWIDTH-1 -: PORTADDRBITS];
        dev_minor <= bus.IOMinorOpcode;
        dev_addr  <= bus.IOOutAddress;
        dev_data  <= bus.IOOutData;
        dev_dest  <= bus.IOOutDestReg;
      end else if (req_done_c || timeout_hit_c) begin
        req_valid <= 1'b0;
      end
    end
  end

  assign bus.DevMinorOpcode = dev_minor;
  assign bus.DevAddress     = dev_addr;
  assign bus.DevData        = dev_data;
  assign bus.DevDestReg     = dev_dest;

`ifdef IOARB_TIMEOUT_EN
  localparam int unsigned TCW = (TIMEOUTCYCLES > 1) ? $clog2(TIMEOUTCYCLES) : 1;
  logic [TCW-1:0] timeout_cnt;
  logic           timeout_flag;

  assign timeout_hit_c = clk_en & req_valid & ~req_done_c &
                         (timeout_cnt == TCW'(TIMEOUTCYCLES - 1));

  // Counts stalled cycles of the buffered request; abandons it at the limit
  always_ff @(posedge clk) begin : watchdog
    if (sync_rst) begin
      timeout_cnt  <= '0;
      timeout_flag <= 1'b0;
    end else if (clk_en) begin
      timeout_flag <= timeout_hit_c;
      if (req_accept_c || req_done_c || timeout_hit_c) timeout_cnt <= '0;
      else if (req_valid)                              timeout_cnt <= timeout_cnt + TCW'(1);
    end
  end

  assign bus.TimeoutFlag = timeout_flag;
`else
  assign timeout_hit_c   = 1'b0;
  assign bus.TimeoutFlag = 1'b0;
`endif

  // ---------------- response path ----------------
  typedef enum logic {RESP_EMPTY, RESP_FULL} resp_state_t;

  resp_state_t             resp_state;
  resp_state_t             resp_state_nxt;
  logic [PORTADDRBITS-1:0] last_grant;
  logic [PORTADDRBITS-1:0] grant_idx_c;
  logic [PORTADDRBITS-1:0] probe_idx;
  logic                    grant_any_c;
  logic                    resp_grant_c;
  logic [REGADDRWIDTH-1:0] resp_tag_c;
  logic [DATABITWIDTH-1:0] resp_data_c;
  logic [REGADDRWIDTH-1:0] in_tag;
  logic [DATABITWIDTH-1:0] in_data;

  // First requester after the last winner, wrapping around
  always_comb begin : rr_search
    grant_any_c = 1'b0;
    grant_idx_c = last_grant;
    probe_idx   = '0;
    for (int unsigned k = 1; k <= PORTCOUNT; k++) begin
      probe_idx = PORTADDRBITS'((32'(last_grant) + k) % PORTCOUNT);
      if (!grant_any_c && bus.DevRespREQ[probe_idx]) begin
        grant_any_c = 1'b1;
        grant_idx_c = probe_idx;
      end
    end
  end

  always_comb begin : resp_payload_mux
    resp_tag_c  = '0;
    resp_data_c = '0;
    for (int unsigned p = 0; p < PORTCOUNT; p++) begin
      if (32'(grant_idx_c) == p) begin
        resp_tag_c  = bus.DevRespDestReg[p*REGADDRWIDTH +: REGADDRWIDTH];
        resp_data_c = bus.DevRespData[p*DATABITWIDTH +: DATABITWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin : resp_state_reg
    if (sync_rst)    resp_state <= RESP_EMPTY;
    else if (clk_en) resp_state <= resp_state_nxt;
  end

  always_comb begin : resp_fsm
    resp_state_nxt = resp_state;
    resp_grant_c   = 1'b0;
    case (resp_state)
      RESP_EMPTY: begin
        if (clk_en && !sync_rst && grant_any_c) begin
          resp_grant_c   = 1'b1;
          resp_state_nxt = RESP_FULL;
        end
      end
      RESP_FULL: begin
        if (clk_en && bus.IOInACK) resp_state_nxt = RESP_EMPTY;
      end
      default: resp_state_nxt = RESP_EMPTY;
    endcase
  end

  always_comb begin : resp_ack_decode
    bus.DevRespACK = '0;
    if (resp_grant_c) bus.DevRespACK[grant_idx_c] = 1'b1;
  end

  always_ff @(posedge clk) begin : resp_buf
    if (sync_rst) begin
      last_grant <= PORTADDRBITS'(PORTCOUNT - 1);
      in_tag     <= '0;
      in_data    <= '0;
    end else if (resp_grant_c) begin
      last_grant <= grant_idx_c;
      in_tag     <= resp_tag_c;
      in_data    <= resp_data_c;
    end
  end

  assign bus.IOInREQ     = (resp_state == RESP_FULL);
  assign bus.IOInDestReg = in_tag;
  assign bus.IOInData    = in_data;

endmodule

// File: tb/tb_io_port_arbiter.sv
// Self-checking bench for io_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_io_port_arbiter;
  localparam int unsigned DW  = 16;
  localparam int unsigned PC  = 4;
  localparam int unsigned RW  = 4;
  localparam int unsigned MW  = 4;
  localparam int unsigned PAB = $clog2(PC);

  logic clk = 1'b0;
  logic clk_en;
  logic sync_rst;
  int   checks   = 0;
  int   failures = 0;

  io_port_arbiter_if #(.DATABITWIDTH(DW), .PORTCOUNT(PC), .REGADDRWIDTH(RW), .MINORWIDTH(MW)) bus ();

  io_port_arbiter #(.DATABITWIDTH(DW), .PORTCOUNT(PC), .REGADDRWIDTH(RW), .MINORWIDTH(MW)) dut (
    .clk      (clk),
    .clk_en   (clk_en),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.IOOutREQ       = 1'b0;
    bus.IOMinorOpcode  = '0;
    bus.IOOutAddress   = '0;
    bus.IOOutData      = '0;
    bus.IOOutDestReg   = '0;
    bus.DevACK         = '0;
    bus.DevRespREQ     = '0;
    bus.DevRespDestReg = '0;
    bus.DevRespData    = '0;
    bus.IOInACK        = 1'b0;
  endtask

  task automatic test_reset();
    sync_rst = 1'b1;
    clk_en   = 1'b1;
    clear_inputs();
    tick();
    tick();
    sync_rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.IOOutACK !== 1'b1) begin failures++; $display("FAIL reset_ioack got=%b exp=1", bus.IOOutACK); end
    checks++; if (bus.DevREQ !== 4'b0) begin failures++; $display("FAIL reset_devreq got=%b exp=0000", bus.DevREQ); end
    checks++; if (bus.DevRespACK !== 4'b0) begin failures++; $display("FAIL reset_rack got=%b exp=0000", bus.DevRespACK); end
    checks++; if (bus.IOInREQ !== 1'b0) begin failures++; $display("FAIL reset_inreq got=%b exp=0", bus.IOInREQ); end
    checks++; if (bus.IOInData !== 16'h0) begin failures++; $display("FAIL reset_indata got=%h exp=0", bus.IOInData); end
    checks++; if (bus.DevData !== 16'h0) begin failures++; $display("FAIL reset_devdata got=%h exp=0", bus.DevData); end
    checks++; if (bus.TimeoutFlag !== 1'b0) begin failures++; $display("FAIL reset_tflag got=%b exp=0", bus.TimeoutFlag); end
    tick();
  endtask

  task automatic test_request();
    bus.IOOutREQ      = 1'b1;
    bus.IOOutAddress  = 16'h4000;
    bus.IOOutData     = 16'hBEEF;
    bus.IOMinorOpcode = 4'h5;
    bus.IOOutDestReg  = 4'h3;
    @(negedge clk);
    checks++; if (bus.IOOutACK !== 1'b1) begin failures++; $display("FAIL req_ready got=%b exp=1", bus.IOOutACK); end
    tick();
    bus.IOOutREQ  = 1'b0;
    bus.IOOutData = 16'h0;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0010) begin failures++; $display("FAIL req_devreq got=%b exp=0010", bus.DevREQ); end
    checks++; if (bus.DevData !== 16'hBEEF) begin failures++; $display("FAIL req_devdata got=%h exp=beef", bus.DevData); end
    checks++; if (bus.DevAddress !== 16'h4000) begin failures++; $display("FAIL req_devaddr got=%h exp=4000", bus.DevAddress); end
    checks++; if (bus.DevMinorOpcode !== 4'h5) begin failures++; $display("FAIL req_minor got=%h exp=5", bus.DevMinorOpcode); end
    checks++; if (bus.DevDestReg !== 4'h3) begin failures++; $display("FAIL req_dest got=%h exp=3", bus.DevDestReg); end
    checks++; if (bus.IOOutACK !== 1'b0) begin failures++; $display("FAIL req_busy got=%b exp=0", bus.IOOutACK); end
    tick();
    bus.DevACK = 4'b1101;
    tick();
    bus.DevACK = 4'b0010;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0010) begin failures++; $display("FAIL req_other_ack got=%b exp=0010", bus.DevREQ); end
    tick();
    bus.DevACK = 4'b0000;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0000) begin failures++; $display("FAIL req_cleared got=%b exp=0000", bus.DevREQ); end
    checks++; if (bus.IOOutACK !== 1'b1) begin failures++; $display("FAIL req_ready_again got=%b exp=1", bus.IOOutACK); end
    tick();
  endtask

  task automatic test_resp_rr();
    logic [PC-1:0] rq;
    logic [DW-1:0] rdata [PC];
    int            ack_cnt [PC];
    int            got_cyc [$];
    int            n;
    rq = '1;
    n  = 0;
    for (int p = 0; p < PC; p++) begin
      rdata[p]   = DW'($urandom);
      ack_cnt[p] = 0;
      bus.DevRespDestReg[p*RW +: RW] = RW'(p + 1);
      bus.DevRespData[p*DW +: DW]    = rdata[p];
    end
    bus.DevRespREQ = rq;
    bus.IOInACK    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.IOInREQ === 1'b1) begin
        if (n < PC) begin
          checks++; if (bus.IOInDestReg !== RW'(n + 1)) begin failures++; $display("FAIL rr_tag got=%0d exp=%0d", bus.IOInDestReg, n + 1); end
          checks++; if (bus.IOInData !== rdata[n]) begin failures++; $display("FAIL rr_data got=%h exp=%h", bus.IOInData, rdata[n]); end
        end
        got_cyc.push_back(c);
        n++;
      end
      if (bus.DevRespACK !== 4'b0) begin
        checks++; if (!$onehot(bus.DevRespACK)) begin failures++; $display("FAIL rr_onehot got=%b exp=onehot", bus.DevRespACK); end
        for (int p = 0; p < PC; p++) if (bus.DevRespACK[p]) ack_cnt[p]++;
        rq = rq & ~bus.DevRespACK;
      end
      tick();
      bus.DevRespREQ = rq;
    end
    bus.IOInACK = 1'b0;
    checks++; if (n != PC) begin failures++; $display("FAIL rr_count got=%0d exp=%0d", n, PC); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] != 2) begin failures++; $display("FAIL rr_spacing got=%0d exp=2", got_cyc[i] - got_cyc[i-1]); end
    end
    for (int p = 0; p < PC; p++) begin
      checks++; if (ack_cnt[p] != 1) begin failures++; $display("FAIL rr_ack_once port=%0d got=%0d exp=1", p, ack_cnt[p]); end
    end
  endtask

  task automatic test_hold();
    bus.IOInACK = 1'b0;
    bus.DevRespDestReg[2*RW +: RW] = 4'h9;
    bus.DevRespData[2*DW +: DW]    = 16'h1234;
    bus.DevRespREQ = 4'b0100;
    @(negedge clk);
    checks++; if (bus.DevRespACK !== 4'b0100) begin failures++; $display("FAIL hold_grant got=%b exp=0100", bus.DevRespACK); end
    tick();
    bus.DevRespREQ = 4'b1011;
    bus.DevRespDestReg[2*RW +: RW] = 4'h0;
    bus.DevRespData[2*DW +: DW]    = 16'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (bus.IOInREQ !== 1'b1) begin failures++; $display("FAIL hold_inreq got=%b exp=1", bus.IOInREQ); end
      checks++; if (bus.IOInDestReg !== 4'h9) begin failures++; $display("FAIL hold_tag got=%h exp=9", bus.IOInDestReg); end
      checks++; if (bus.IOInData !== 16'h1234) begin failures++; $display("FAIL hold_data got=%h exp=1234", bus.IOInData); end
      checks++; if (bus.DevRespACK !== 4'b0) begin failures++; $display("FAIL hold_rack got=%b exp=0000", bus.DevRespACK); end
      tick();
    end
    bus.IOInACK = 1'b1;
    tick();
    bus.IOInACK = 1'b0;
    @(negedge clk);
    checks++; if (bus.DevRespACK !== 4'b1000) begin failures++; $display("FAIL hold_next_grant got=%b exp=1000", bus.DevRespACK); end
    tick();
    bus.DevRespREQ = 4'b0;
    bus.IOInACK    = 1'b1;
    tick();
    tick();
    bus.IOInACK = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.IOOutREQ     = 1'b1;
    bus.IOOutAddress = 16'h4000;
    bus.IOOutData    = 16'hA5A5;
    bus.DevRespREQ   = 4'b0100;
    bus.IOInACK      = 1'b0;
    tick();
    bus.IOOutREQ = 1'b0;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0010) begin failures++; $display("FAIL rstmid_pre_devreq got=%b exp=0010", bus.DevREQ); end
    checks++; if (bus.IOInREQ !== 1'b1) begin failures++; $display("FAIL rstmid_pre_inreq got=%b exp=1", bus.IOInREQ); end
    tick();
    sync_rst = 1'b1;
    tick();
    sync_rst       = 1'b0;
    bus.DevRespREQ = 4'b1111;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0) begin failures++; $display("FAIL rstmid_devreq got=%b exp=0000", bus.DevREQ); end
    checks++; if (bus.IOInREQ !== 1'b0) begin failures++; $display("FAIL rstmid_inreq got=%b exp=0", bus.IOInREQ); end
    checks++; if (bus.DevRespACK !== 4'b0001) begin failures++; $display("FAIL rstmid_grant got=%b exp=0001", bus.DevRespACK); end
    checks++; if (bus.IOOutACK !== 1'b1) begin failures++; $display("FAIL rstmid_ioack got=%b exp=1", bus.IOOutACK); end
    tick();
    bus.DevRespREQ = 4'b0;
    bus.IOInACK    = 1'b1;
    tick();
    tick();
    bus.IOInACK = 1'b0;
  endtask

`ifdef IOARB_TIMEOUT_EN
  task automatic test_timeout();
    int high_cycles;
    bit seen;
    high_cycles = 0;
    seen        = 1'b0;
    bus.DevACK       = '0;
    bus.IOOutREQ     = 1'b1;
    bus.IOOutAddress = 16'h4000;
    tick();
    bus.IOOutREQ = 1'b0;
    for (int c = 0; c < 1100 && !seen; c++) begin
      @(negedge clk);
      if (bus.TimeoutFlag === 1'b1) begin
        seen = 1'b1;
        checks++; if (bus.DevREQ !== 4'b0) begin failures++; $display("FAIL to_devreq got=%b exp=0000", bus.DevREQ); end
        checks++; if (bus.IOOutACK !== 1'b1) begin failures++; $display("FAIL to_ioack got=%b exp=1", bus.IOOutACK); end
        checks++; if (high_cycles != 1024) begin failures++; $display("FAIL to_latency got=%0d exp=1024", high_cycles); end
      end else if (bus.DevREQ === 4'b0010) begin
        high_cycles++;
      end
      tick();
    end
    checks++; if (!seen) begin failures++; $display("FAIL to_seen got=0 exp=1"); end
    @(negedge clk);
    checks++; if (bus.TimeoutFlag !== 1'b0) begin failures++; $display("FAIL to_pulse got=%b exp=0", bus.TimeoutFlag); end
    tick();
  endtask
`else
  task automatic test_timeout();
    bus.DevACK       = '0;
    bus.IOOutREQ     = 1'b1;
    bus.IOOutAddress = 16'h4000;
    tick();
    bus.IOOutREQ = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++; if (bus.DevREQ !== 4'b0010) begin failures++; $display("FAIL nto_devreq got=%b exp=0010", bus.DevREQ); end
      checks++; if (bus.TimeoutFlag !== 1'b0) begin failures++; $display("FAIL nto_tflag got=%b exp=0", bus.TimeoutFlag); end
      tick();
    end
    bus.DevACK = 4'b0010;
    tick();
    bus.DevACK = 4'b0;
    @(negedge clk);
    checks++; if (bus.DevREQ !== 4'b0) begin failures++; $display("FAIL nto_release got=%b exp=0000", bus.DevREQ); end
    tick();
  endtask
`endif

  // Random CPU/device traffic with random clock-enable gaps against a transaction model
  task automatic test_random();
    bit            m_pend, m_full, cpu_req;
    int            m_port, m_last, gp, p;
    logic [DW-1:0] m_addr, m_data, m_rdata, c_addr, c_data;
    logic [MW-1:0] m_minor, c_minor;
    logic [RW-1:0] m_dest, m_tag, c_dest;
    logic [PC-1:0] dv, dack, exp_rack, exp_devreq;
    logic [RW-1:0] d_tag [PC];
    logic [DW-1:0] d_data [PC];
    logic          inack;
    m_pend = 0; m_full = 0; cpu_req = 0; m_last = PC - 1; m_port = 0;
    m_addr = '0; m_data = '0; m_rdata = '0; m_minor = '0; m_dest = '0; m_tag = '0;
    c_addr = '0; c_data = '0; c_minor = '0; c_dest = '0; dv = '0;
    for (int i = 0; i < PC; i++) begin d_tag[i] = '0; d_data[i] = '0; end
    clear_inputs();
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      clk_en = ($urandom_range(0, 7) != 0);
      if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; c_addr = DW'($urandom); c_data = DW'($urandom);
        c_minor = MW'($urandom); c_dest = RW'($urandom);
      end
      for (int i = 0; i < PC; i++) begin
        if (!dv[i] && $urandom_range(0, 3) == 0) begin
          dv[i] = 1'b1; d_tag[i] = RW'($urandom); d_data[i] = DW'($urandom);
        end
        bus.DevRespDestReg[i*RW +: RW] = d_tag[i];
        bus.DevRespData[i*DW +: DW]    = d_data[i];
      end
      dack  = PC'($urandom);
      inack = 1'($urandom_range(0, 1));
      bus.IOOutREQ = cpu_req; bus.IOOutAddress = c_addr; bus.IOOutData = c_data;
      bus.IOMinorOpcode = c_minor; bus.IOOutDestReg = c_dest;
      bus.DevACK = dack; bus.IOInACK = inack; bus.DevRespREQ = dv;
      @(negedge clk);
      exp_rack = '0;
      gp = -1;
      if (clk_en && !m_full) begin
        for (int k = 1; k <= PC; k++) begin
          p = (m_last + k) % PC;
          if (gp < 0 && dv[p]) gp = p;
        end
      end
      if (gp >= 0) exp_rack[gp] = 1'b1;
      exp_devreq = '0;
      if (m_pend) exp_devreq[m_port] = 1'b1;
      checks++; if (bus.IOOutACK !== (clk_en && !m_pend)) begin failures++; $display("FAIL rnd_ioack cyc=%0d got=%b exp=%b", cyc, bus.IOOutACK, clk_en && !m_pend); end
      checks++; if (bus.DevREQ !== exp_devreq) begin failures++; $display("FAIL rnd_devreq cyc=%0d got=%b exp=%b", cyc, bus.DevREQ, exp_devreq); end
      checks++; if (bus.DevRespACK !== exp_rack) begin failures++; $display("FAIL rnd_rack cyc=%0d got=%b exp=%b", cyc, bus.DevRespACK, exp_rack); end
      checks++; if (bus.IOInREQ !== m_full) begin failures++; $display("FAIL rnd_inreq cyc=%0d got=%b exp=%b", cyc, bus.IOInREQ, m_full); end
      checks++; if (bus.TimeoutFlag !== 1'b0) begin failures++; $display("FAIL rnd_tflag cyc=%0d got=%b exp=0", cyc, bus.TimeoutFlag); end
      if (m_pend) begin
        checks++; if (bus.DevAddress !== m_addr || bus.DevData !== m_data || bus.DevMinorOpcode !== m_minor || bus.DevDestReg !== m_dest) begin
          failures++; $display("FAIL rnd_devfields cyc=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", cyc,
            bus.DevAddress, bus.DevData, bus.DevMinorOpcode, bus.DevDestReg, m_addr, m_data, m_minor, m_dest);
        end
      end
      if (m_full) begin
        checks++; if (bus.IOInDestReg !== m_tag || bus.IOInData !== m_rdata) begin
          failures++; $display("FAIL rnd_resp cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.IOInDestReg, bus.IOInData, m_tag, m_rdata);
        end
      end
      if (clk_en) begin
        if (!m_pend && cpu_req) begin
          m_pend = 1; m_port = int'(c_addr[DW-1 -: PAB]);
          m_addr = c_addr; m_data = c_data; m_minor = c_minor; m_dest = c_dest;
          cpu_req = 0;
        end else if (m_pend && dack[m_port]) begin
          m_pend = 0;
        end
        if (gp >= 0) begin
          m_full = 1; m_last = gp; m_tag = d_tag[gp]; m_rdata = d_data[gp]; dv[gp] = 1'b0;
        end else if (m_full && inack) begin
          m_full = 0;
        end
      end
      tick();
    end
    clk_en = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clk_en   = 1'b1;
    sync_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_request();
    test_resp_rr();
    test_hold();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
